clock_div_ctrl: RTL and testbench

Runtime controller for a programmable clock divider. It holds the active divisor and generates the divided clock and a per-period tick enable. It accepts divisor-change requests over a req/ack handshake, and applies changes and stops only on a period boundary, so no runt pulses are produced. It sits between the config/control logic and the slow-clock consumers: LED scanners, debouncers and UART baud timing.

---
 rtl/clock_div_ctrl_pkg.sv | 13 +
 rtl/clock_div_ctrl_div_counter.sv | 38 +++
 rtl/clock_div_ctrl.sv | 109 ++++++++++
 tb/tb_clock_div_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_div_ctrl_pkg.sv
// Shared definitions for the programmable clock divider controller.
// State encodings and the smallest divisor the period counter can honour.
package clock_div_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clock_div_ctrl_div_counter.sv
// Period counter for the clock divider: wraps at active_div-1 and produces
// the registered divided clock and the end-of-period tick.
module clock_div_ctrl_div_counter #(
   parameter int unsigned WIDTH = 28
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic             run,
   input  logic [WIDTH-1:0] active_div,
   output logic             terminal,
   output logic             clock_out,
   output logic             tick
);

   logic [WIDTH-1:0] counter;
   logic [WIDTH-1:0] last_count;

   assign last_count = active_div - WIDTH'(1);
   assign terminal   = run && (counter == last_count);

   // Odd divisors: the high phase is floor(div/2), so the low phase gets the extra cycle.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         counter   <= '0;
         clock_out <= 1'b0;
         tick      <= 1'b0;
      end else if (!run) begin
         counter   <= '0;
         clock_out <= 1'b0;
         tick      <= 1'b0;
      end else begin
         counter   <= terminal ? '0 : counter + WIDTH'(1);
         clock_out <= (counter < (active_div >> 1));
         tick      <= terminal;
      end
   end

endmodule

// File: rtl/clock_div_ctrl.sv
// Runtime controller for a programmable clock divider: divisor handshake and
// run/stop sequencing, with every change and stop aligned to a period boundary.
//
// state | meaning
// IDLE  | divider stopped, counter held at 0, divisor may be loaded directly
// RUN   | divider counting with active_div
// PEND  | counting; a valid divisor change waits for the period boundary
module clock_div_ctrl
   import clock_div_ctrl_pkg::*;
#(
   parameter int unsigned      WIDTH       = 28,
   parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(2)
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             div_req,
   input  logic [WIDTH-1:0] div_value,
   output logic             div_ack,
   output logic             div_err,
   output logic             clock_out,
   output logic             tick,
   output logic             busy,
   output logic [WIDTH-1:0] active_div
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] active_div_nxt;
   logic             ack_nxt;
   logic             err_nxt;
   logic             busy_nxt;
   logic             req_seen;
   logic             req_valid;
   logic             terminal;

   // The cycle after an ack/err still sees the old request level; ignore it.
   assign req_seen  = div_req && !div_ack && !div_err;
   assign req_valid = (div_value >= WIDTH'(MIN_DIV));

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         active_div <= DEFAULT_DIV;
         div_ack    <= 1'b0;
         div_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         active_div <= active_div_nxt;
         div_ack    <= ack_nxt;
         div_err    <= err_nxt;
         busy       <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      active_div_nxt = active_div;
      ack_nxt        = 1'b0;
      busy_nxt       = busy;
      err_nxt        = req_seen && !req_valid;
      unique case (state)
         IDLE: begin
            if (req_seen && req_valid) begin
               active_div_nxt = div_value;
               ack_nxt        = 1'b1;
            end
            if (enable) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            // A stop at this boundary wins; a request still held is then taken in IDLE.
            if (terminal && !enable) begin
               state_nxt = IDLE;
            end else if (req_seen && req_valid) begin
               state_nxt = PEND;
               busy_nxt  = 1'b1;
            end
         end
         PEND: begin
            if (terminal) begin
               active_div_nxt = div_value;
               ack_nxt        = 1'b1;
               busy_nxt       = 1'b0;
               state_nxt      = enable ? RUN : IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   clock_div_ctrl_div_counter #(
      .WIDTH (WIDTH)
   ) u_div_counter (
      .clock_in   (clock_in),
      .reset_n    (reset_n),
      .run        (state != IDLE),
      .active_div (active_div),
      .terminal   (terminal),
      .clock_out  (clock_out),
      .tick       (tick)
   );

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed bench for clock_div_ctrl: expected per-cycle outputs are queued as
// each step is driven and compared one clock later as the DUT produces them.
module tb_clock_div_ctrl;

   localparam int W = 28;

   logic         clock_in;
   logic         reset_n;
   logic         enable;
   logic         div_req;
   logic [W-1:0] div_value;
   logic         div_ack;
   logic         div_err;
   logic         clock_out;
   logic         tick;
   logic         busy;
   logic [W-1:0] active_div;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string        tag;
      logic         co;
      logic         tk;
      logic         ack;
      logic         err;
      logic         bsy;
      logic [W-1:0] div;
   } exp_t;

   exp_t sb[$];

   clock_div_ctrl #(
      .WIDTH       (W),
      .DEFAULT_DIV (28'd2)
   ) dut (
      .clock_in   (clock_in),
      .reset_n    (reset_n),
      .enable     (enable),
      .div_req    (div_req),
      .div_value  (div_value),
      .div_ack    (div_ack),
      .div_err    (div_err),
      .clock_out  (clock_out),
      .tick       (tick),
      .busy       (busy),
      .active_div (active_div)
   );

   initial clock_in = 1'b0;
   always #5 clock_in = ~clock_in;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cmp(input string tag, input string field,
                      input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic co, input logic tk,
                       input logic ack, input logic err, input logic bsy,
                       input logic [W-1:0] div);
      exp_t e;
      e.tag = tag; e.co = co; e.tk = tk; e.ack = ack; e.err = err; e.bsy = bsy; e.div = div;
      sb.push_back(e);
   endtask

   // Queue a run of quiet cycles (no handshake activity) from clock_out/tick bit strings.
   task automatic push_seq(input string tag, input logic [W-1:0] div,
                           input string co_s, input string tk_s);
      for (int i = 0; i < co_s.len(); i++) begin
         push(tag, co_s.substr(i, i) == "1", tk_s.substr(i, i) == "1", 1'b0, 1'b0, 1'b0, div);
      end
   endtask

   task automatic check_now();
      exp_t e;
      if (sb.size() == 0) begin
         cmp("scoreboard", "underflow", 28'd1, 28'd0);
      end else begin
         e = sb.pop_front();
         cmp(e.tag, "clock_out",  W'(clock_out), W'(e.co));
         cmp(e.tag, "tick",       W'(tick),      W'(e.tk));
         cmp(e.tag, "div_ack",    W'(div_ack),   W'(e.ack));
         cmp(e.tag, "div_err",    W'(div_err),   W'(e.err));
         cmp(e.tag, "busy",       W'(busy),      W'(e.bsy));
         cmp(e.tag, "active_div", active_div,    e.div);
      end
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock_in);
         #1;
         check_now();
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      enable    = 1'b0;
      div_req   = 1'b0;
      div_value = '0;
      repeat (2) @(posedge clock_in);
      #1;
      push("reset", 0, 0, 0, 0, 0, 28'd2);
      check_now();

      // default divisor 2, then stop at the period boundary
      reset_n = 1'b1;
      enable  = 1'b1;
      push_seq("t1_div2", 28'd2, "010101", "001010");
      drain(6);
      enable = 1'b0;
      push_seq("t1_stop", 28'd2, "000", "100");
      drain(3);

      // load 5 while idle, then run
      div_req = 1'b1; div_value = 28'd5;
      push("t2_ack", 0, 0, 1, 0, 0, 28'd5);
      drain(1);
      div_req = 1'b0;
      push("t2_ack_end", 0, 0, 0, 0, 0, 28'd5);
      drain(1);
      enable = 1'b1;
      push_seq("t2_div5", 28'd5, "01100011000", "00000100001");
      drain(11);

      // change 5 -> 4 on the fly, requested at counter 0
      div_req = 1'b1; div_value = 28'd4;
      push("t3_pend4", 1, 0, 0, 0, 1, 28'd5);
      push("t3_pend4", 1, 0, 0, 0, 1, 28'd5);
      push("t3_pend4", 0, 0, 0, 0, 1, 28'd5);
      push("t3_pend4", 0, 0, 0, 0, 1, 28'd5);
      push("t3_ack4",  0, 1, 1, 0, 0, 28'd4);
      drain(5);
      div_req = 1'b0;
      push_seq("t3_div4", 28'd4, "11001", "00010");
      drain(5);

      // change 4 -> 6 requested at counter 1
      div_req = 1'b1; div_value = 28'd6;
      push("t3_busy", 1, 0, 0, 0, 1, 28'd4);
      push("t3_busy", 0, 0, 0, 0, 1, 28'd4);
      push("t3_ack6", 0, 1, 1, 0, 0, 28'd6);
      drain(3);
      div_req = 1'b0;
      push_seq("t3_div6", 28'd6, "1110001", "0000010");
      drain(7);

      // invalid divisors 1 and 0 while running
      div_req = 1'b1; div_value = 28'd1;
      push("t4_err1", 1, 0, 0, 1, 0, 28'd6);
      drain(1);
      div_req = 1'b0;
      push("t4_gap", 1, 0, 0, 0, 0, 28'd6);
      drain(1);
      div_req = 1'b1; div_value = 28'd0;
      push("t4_err0", 0, 0, 0, 1, 0, 28'd6);
      drain(1);
      div_req = 1'b0;
      push_seq("t4_run", 28'd6, "001", "010");
      drain(3);

      // change 6 -> 8, then drop enable at counter 2
      div_req = 1'b1; div_value = 28'd8;
      push("t5_pend8", 1, 0, 0, 0, 1, 28'd6);
      push("t5_pend8", 1, 0, 0, 0, 1, 28'd6);
      push("t5_pend8", 0, 0, 0, 0, 1, 28'd6);
      push("t5_pend8", 0, 0, 0, 0, 1, 28'd6);
      push("t5_ack8",  0, 1, 1, 0, 0, 28'd8);
      drain(5);
      div_req = 1'b0;
      push_seq("t5_div8", 28'd8, "11", "00");
      drain(2);
      enable = 1'b0;
      push_seq("t5_stop", 28'd8, "110000000", "000001000");
      drain(9);

      // invalid request while idle
      div_req = 1'b1; div_value = 28'd0;
      push("idle_err", 0, 0, 0, 1, 0, 28'd8);
      drain(1);
      div_req = 1'b0;
      push("idle_err_end", 0, 0, 0, 0, 0, 28'd8);
      drain(1);

      // reset while a change 8 -> 3 is pending
      enable = 1'b1;
      push_seq("t6_run", 28'd8, "01", "00");
      drain(2);
      div_req = 1'b1; div_value = 28'd3;
      push("t6_pend", 1, 0, 0, 0, 1, 28'd8);
      drain(1);
      reset_n = 1'b0;
      #1;
      push("t6_rst", 0, 0, 0, 0, 0, 28'd2);
      check_now();
      div_req = 1'b0;
      enable  = 1'b0;
      #1;
      reset_n = 1'b1;
      push_seq("t6_after", 28'd2, "0000", "0000");
      drain(4);

      cmp("scoreboard", "leftover", W'(sb.size()), 28'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
